ctrl_fsm_param: RTL and testbench

//  Parametrised multi-cycle control FSM for the simple processor datapath; next generation of the 8-register control unit.

---
 rtl/ctrl_pkg.sv | 19 +
 rtl/onehot_dec.sv | 15 +
 rtl/ctrl_fsm_param.sv | 171 +++++++++++++++++
 tb/tb_ctrl_fsm_param.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared types for the processor control unit: time-step encoding and opcode values.
package ctrl_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  localparam int unsigned OP_MV   = 0;
  localparam int unsigned OP_MVI  = 1;
  localparam int unsigned OP_ADD  = 2;
  localparam int unsigned OP_SUB  = 3;
  localparam int unsigned OP_MVNZ = 4;
  localparam int unsigned OP_LD   = 5;
  localparam int unsigned OP_ST   = 6;

endpackage

// File: rtl/onehot_dec.sv
// N-to-2**N one-hot decoder with enable; output is all zero when disabled.
module onehot_dec #(
  parameter int unsigned N = 3
) (
  input  logic            en,
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
  end

endmodule

// File: rtl/ctrl_fsm_param.sv
// Multi-cycle control FSM (T0..T3) decoding IR = {op, X, Y} into datapath controls.
// Optional memory ld/st path enabled by defining CTRL_MEM_EN; otherwise those opcodes are NOPs.
module ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int unsigned REG_BITS = 3,
  parameter int unsigned OP_BITS  = 3,
  parameter int unsigned IW       = OP_BITS + 2 * REG_BITS,
  localparam int unsigned NREGS   = 2 ** REG_BITS
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             Run,
  input  logic [IW-1:0]    IRout,
  input  logic             Gnz,
  input  logic             mem_rdy,
  output logic             Done,
  output logic [NREGS-1:0] Rout,
  output logic [NREGS-1:0] Rin,
  output logic             Gout,
  output logic             DINout,
  output logic             IRin,
  output logic             Ain,
  output logic             Gin,
  output logic             AddSub,
  output logic             pc_inc,
  output logic             ADDRin,
  output logic             DOUTin,
  output logic             W_D
);

  state_t               state_q, state_d;
  logic [OP_BITS-1:0]   op;
  logic [REG_BITS-1:0]  x_sel, y_sel;
  logic [NREGS-1:0]     x_oh, y_oh;

  assign op    = IRout[IW-1 -: OP_BITS];
  assign x_sel = IRout[2*REG_BITS-1 -: REG_BITS];
  assign y_sel = IRout[REG_BITS-1:0];

`ifndef CTRL_MEM_EN
  logic unused_mem;
  assign unused_mem = mem_rdy;
`endif

  onehot_dec #(.N(REG_BITS)) u_x_dec (
    .en  (Resetn),
    .sel (x_sel),
    .dec (x_oh)
  );

  onehot_dec #(.N(REG_BITS)) u_y_dec (
    .en  (Resetn),
    .sel (y_sel),
    .dec (y_oh)
  );

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= T0;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = T0;
    unique case (state_q)
      T0: state_d = Run ? T1 : T0;
      T1: state_d = Done ? T0 : T2;
      T2: begin
        state_d = Done ? T0 : T3;
`ifdef CTRL_MEM_EN
        // Load waits in T2 until the memory returns data.
        if (op == OP_BITS'(OP_LD) && !mem_rdy) state_d = T2;
`endif
      end
      T3: state_d = T0;
      default: state_d = T0;
    endcase
  end

  always_comb begin
    Done   = 1'b0;
    Rout   = '0;
    Rin    = '0;
    Gout   = 1'b0;
    DINout = 1'b0;
    IRin   = 1'b0;
    Ain    = 1'b0;
    Gin    = 1'b0;
    AddSub = 1'b0;
    pc_inc = 1'b0;
    ADDRin = 1'b0;
    DOUTin = 1'b0;
    W_D    = 1'b0;
    if (Resetn) begin
      unique case (state_q)
        T0: begin
          IRin   = Run;
          pc_inc = Run;
        end
        T1: begin
          case (op)
            OP_BITS'(OP_MV): begin
              Rout = y_oh;
              Rin  = x_oh;
              Done = 1'b1;
            end
            OP_BITS'(OP_MVI): begin
              DINout = 1'b1;
              Rin    = x_oh;
              pc_inc = 1'b1;
              Done   = 1'b1;
            end
            OP_BITS'(OP_ADD), OP_BITS'(OP_SUB): begin
              Rout = x_oh;
              Ain  = 1'b1;
            end
            OP_BITS'(OP_MVNZ): begin
              Rout = y_oh;
              Rin  = Gnz ? x_oh : '0;
              Done = 1'b1;
            end
`ifdef CTRL_MEM_EN
            OP_BITS'(OP_LD), OP_BITS'(OP_ST): begin
              Rout   = y_oh;
              ADDRin = 1'b1;
            end
`endif
            default: Done = 1'b1;
          endcase
        end
        T2: begin
          case (op)
            OP_BITS'(OP_ADD), OP_BITS'(OP_SUB): begin
              Rout   = y_oh;
              Gin    = 1'b1;
              AddSub = (op == OP_BITS'(OP_SUB));
            end
`ifdef CTRL_MEM_EN
            OP_BITS'(OP_ST): begin
              Rout   = x_oh;
              DOUTin = 1'b1;
              W_D    = 1'b1;
              Done   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        T3: begin
          case (op)
            OP_BITS'(OP_ADD), OP_BITS'(OP_SUB): begin
              Gout = 1'b1;
              Rin  = x_oh;
              Done = 1'b1;
            end
`ifdef CTRL_MEM_EN
            OP_BITS'(OP_LD): begin
              DINout = 1'b1;
              Rin    = x_oh;
              Done   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// Randomized self-checking bench: a per-instruction cycle script model versus the control FSM.
module tb_ctrl_fsm_param;

`ifdef CTRL_MEM_EN
  localparam bit MemEn = 1'b1;
`else
  localparam bit MemEn = 1'b0;
`endif

  logic       Clock, Resetn, Run, Gnz, mem_rdy;
  logic [8:0] IRout;
  logic       Done, Gout, DINout, IRin, Ain, Gin, AddSub, pc_inc, ADDRin, DOUTin, W_D;
  logic [7:0] Rout, Rin;

  typedef struct packed {
    logic       done;
    logic [7:0] rout;
    logic [7:0] rin;
    logic       gout, dinout, irin, ain, gin, addsub, pc_inc, addrin, doutin, w_d;
  } outs_t;

  typedef struct {
    logic  run;
    logic  rdy;
    outs_t exp;
  } cyc_t;

  cyc_t cyc_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  ctrl_fsm_param dut (
    .Clock   (Clock),
    .Resetn  (Resetn),
    .Run     (Run),
    .IRout   (IRout),
    .Gnz     (Gnz),
    .mem_rdy (mem_rdy),
    .Done    (Done),
    .Rout    (Rout),
    .Rin     (Rin),
    .Gout    (Gout),
    .DINout  (DINout),
    .IRin    (IRin),
    .Ain     (Ain),
    .Gin     (Gin),
    .AddSub  (AddSub),
    .pc_inc  (pc_inc),
    .ADDRin  (ADDRin),
    .DOUTin  (DOUTin),
    .W_D     (W_D)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic outs_t observed();
    outs_t o;
    o = '{done: Done, rout: Rout, rin: Rin, gout: Gout, dinout: DINout, irin: IRin, ain: Ain,
          gin: Gin, addsub: AddSub, pc_inc: pc_inc, addrin: ADDRin, doutin: DOUTin, w_d: W_D};
    return o;
  endfunction

  task automatic push(input logic run, input logic rdy, input outs_t e);
    cyc_t c;
    c.run = run;
    c.rdy = rdy;
    c.exp = e;
    cyc_q.push_back(c);
  endtask

  // Cycle script for one instruction, written from the opcode table.
  task automatic model(input int op, input int x, input int y, input bit gnz, input int stalls);
    outs_t e;
    logic [7:0] xo, yo;
    xo = 8'(1 << x);
    yo = 8'(1 << y);
    e = '0; e.irin = 1'b1; e.pc_inc = 1'b1;
    push(1'b1, 1'($urandom), e);
    if (op == 0) begin
      e = '0; e.rout = yo; e.rin = xo; e.done = 1'b1;
      push(1'($urandom), 1'($urandom), e);
    end else if (op == 1) begin
      e = '0; e.dinout = 1'b1; e.rin = xo; e.pc_inc = 1'b1; e.done = 1'b1;
      push(1'($urandom), 1'($urandom), e);
    end else if (op == 2 || op == 3) begin
      e = '0; e.rout = xo; e.ain = 1'b1;
      push(1'($urandom), 1'($urandom), e);
      e = '0; e.rout = yo; e.gin = 1'b1; e.addsub = (op == 3);
      push(1'($urandom), 1'($urandom), e);
      e = '0; e.gout = 1'b1; e.rin = xo; e.done = 1'b1;
      push(1'($urandom), 1'($urandom), e);
    end else if (op == 4) begin
      e = '0; e.rout = yo; e.rin = gnz ? xo : 8'h00; e.done = 1'b1;
      push(1'($urandom), 1'($urandom), e);
    end else if (MemEn && op == 5) begin
      e = '0; e.rout = yo; e.addrin = 1'b1;
      push(1'($urandom), 1'($urandom), e);
      for (int i = 0; i < stalls; i++) push(1'($urandom), 1'b0, '0);
      push(1'($urandom), 1'b1, '0);
      e = '0; e.dinout = 1'b1; e.rin = xo; e.done = 1'b1;
      push(1'($urandom), 1'($urandom), e);
    end else if (MemEn && op == 6) begin
      e = '0; e.rout = yo; e.addrin = 1'b1;
      push(1'($urandom), 1'($urandom), e);
      e = '0; e.rout = xo; e.doutin = 1'b1; e.w_d = 1'b1; e.done = 1'b1;
      push(1'($urandom), 1'($urandom), e);
    end else begin
      e = '0; e.done = 1'b1;
      push(1'($urandom), 1'($urandom), e);
    end
  endtask

  // Drive and check up to n queued cycles; entry/exit at 1 time unit after a rising edge.
  task automatic play(input string tag, input bit gnz, input int n);
    cyc_t c;
    int   k;
    k = 0;
    while (cyc_q.size() > 0 && k < n) begin
      c = cyc_q.pop_front();
      Run = c.run; mem_rdy = c.rdy; Gnz = gnz;
      #1;
      check($sformatf("%s_c%0d", tag, k), 32'(observed()), 32'(c.exp));
      @(posedge Clock); #1;
      k++;
    end
  endtask

  task automatic instr(input string tag, input int op, input int x, input int y, input bit gnz,
                       input int stalls);
    IRout = {3'(op), 3'(x), 3'(y)};
    model(op, x, y, gnz, stalls);
    play(tag, gnz, 1000);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      IRout = 9'($urandom);
      push(1'b0, 1'($urandom), '0);
    end
    play(tag, 1'($urandom), n);
  endtask

  initial begin
    Resetn = 1'b0; Run = 1'b1; Gnz = 1'b0; mem_rdy = 1'b0; IRout = 9'b001_010_000;
    #2;
    check("reset_outs", 32'(observed()), 32'h0);
    @(posedge Clock); @(posedge Clock); #1;
    Resetn = 1'b1;

    instr("mvi_r2", 1, 2, 0, 1'b0, 0);
    instr("add_r1_r3", 2, 1, 3, 1'b0, 0);
    instr("mvnz_gnz0", 4, 0, 5, 1'b0, 0);
    instr("mvnz_gnz1", 4, 0, 5, 1'b1, 0);
    instr("ld_r4_r6", 5, 4, 6, 1'b0, 3);
    instr("st_r3_r7", 6, 3, 7, 1'b0, 0);
    idle("idle5", 5);
    instr("nop111", 7, 6, 1, 1'b1, 0);

    // Reset pulse in T2 of a subtract: outputs drop at once and Rx is never written.
    IRout = {3'd3, 3'd5, 3'd2};
    model(3, 5, 2, 1'b0, 0);
    play("sub_pre", 1'b0, 2);
    Run = 1'b0; mem_rdy = 1'b1;
    #1;
    check("sub_t2", 32'(observed()), 32'(cyc_q[0].exp));
    Resetn = 1'b0;
    #1;
    check("rst_mid", 32'(observed()), 32'h0);
    cyc_q.delete();
    @(posedge Clock); #1;
    check("rst_held", 32'(observed()), 32'h0);
    Resetn = 1'b1;
    idle("post_rst", 2);
    instr("post_rst_mv", 0, 7, 4, 1'b0, 0);

    for (int i = 0; i < 200; i++) begin
      idle($sformatf("r%0d_idle", i), int'($urandom_range(0, 2)));
      instr($sformatf("r%0d_op", i), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
